// File: rtl/rx_matched_filter_if.sv
// Sample/decision bus for one receive branch of the matched filter.
// Build macro RX_SOFT_EN adds the rx_soft output.
interface rx_matched_filter_if #(
  parameter int IN_NBITS    = 8,
  parameter int OUT_NBITS   = 8,
  parameter int PHASE_NBITS = 2
);
  logic                        enable;
  logic signed [IN_NBITS-1:0]  rx_in;
  logic [PHASE_NBITS-1:0]      phase;
  logic                        rx_bit;
  logic                        rx_valid;
`ifdef RX_SOFT_EN
  logic signed [OUT_NBITS-1:0] rx_soft;

  modport master (
    output enable, rx_in, phase,
    input  rx_bit, rx_valid, rx_soft
  );

  modport slave (
    input  enable, rx_in, phase,
    output rx_bit, rx_valid, rx_soft
  );
`else
  modport master (
    output enable, rx_in, phase,
    input  rx_bit, rx_valid
  );

  modport slave (
    input  enable, rx_in, phase,
    output rx_bit, rx_valid
  );
`endif
endinterface

// File: rtl/rx_matched_filter.sv
// Receive matched FIR, decimator and hard-bit slicer for one I/Q branch.
// Build macro RX_SOFT_EN adds a saturated soft output (rx_soft).
module rx_matched_filter #(
  parameter int UPSAMPLE   = 4,
  parameter int NCOEF      = 24,
  parameter int COEF_NBITS = 8,
  parameter logic [NCOEF*COEF_NBITS-1:0] COEF = '0,
  parameter int COEF_FBITS = 7,
  parameter int IN_NBITS   = 8,
  parameter int IN_FBITS   = 7,
  parameter int OUT_NBITS  = 8,
  parameter int OUT_FBITS  = 7
) (
  input logic clk,
  input logic reset,
  rx_matched_filter_if.slave bus
);

  localparam int PW = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam int ACC_NBITS = IN_NBITS + COEF_NBITS + $clog2(NCOEF);
  localparam int F  = IN_FBITS + COEF_FBITS;
  localparam int HI = F + OUT_NBITS - OUT_FBITS - 1;
  localparam int LO = F - OUT_FBITS;

  logic signed [IN_NBITS-1:0]  x [NCOEF];
  logic [PW-1:0]               cnt;
  logic                        tag0;
  logic                        tag_q;
  logic signed [ACC_NBITS-1:0] sum;
  logic signed [ACC_NBITS-1:0] acc_q;
  logic                        bit_q;
  logic                        valid_q;
  logic                        unused_acc;

  function automatic logic signed [COEF_NBITS-1:0] tap(input int k);
    tap = COEF[(NCOEF-k)*COEF_NBITS-1 -: COEF_NBITS];
  endfunction

  // Sample delay line, advanced only on qualified samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCOEF; k++) x[k] <= '0;
    end else if (bus.enable) begin
      x[0] <= bus.rx_in;
      for (int k = 1; k < NCOEF; k++) x[k] <= x[k-1];
    end
  end

  // Symbol phase counter; tags the sample taken at the chosen phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tag0 <= 1'b0;
    end else begin
      tag0 <= bus.enable && (cnt == bus.phase);
      if (bus.enable)
        cnt <= (cnt == PW'(UPSAMPLE-1)) ? '0 : cnt + 1'b1;
    end
  end

  // Full-precision convolution over the delay line
  always_comb begin
    sum = '0;
    for (int k = 0; k < NCOEF; k++)
      sum = sum + ACC_NBITS'(tap(k)) * ACC_NBITS'(x[k]);
  end

  // Register the filter output and its tag every clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      tag_q <= 1'b0;
    end else begin
      acc_q <= sum;
      tag_q <= tag0;
    end
  end

  assign unused_acc = ^acc_q;

`ifdef RX_SOFT_EN
  logic [ACC_NBITS-HI-1:0]     soft_top;
  logic signed [OUT_NBITS-1:0] soft_d;
  logic signed [OUT_NBITS-1:0] soft_q;

  assign soft_top = acc_q[ACC_NBITS-1:HI];

  // Truncate to the soft format, clamping when the top bits overflow it
  always_comb begin
    soft_d = acc_q[HI:LO];
    if (!((&soft_top) || !(|soft_top)))
      soft_d = acc_q[ACC_NBITS-1]
             ? {1'b1, {(OUT_NBITS-1){1'b0}}}
             : {1'b0, {(OUT_NBITS-1){1'b1}}};
  end

  // Soft value captured with each decision, held between strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      soft_q <= '0;
    else if (tag_q)
      soft_q <= soft_d;
  end

  assign bus.rx_soft = soft_q;
`endif

  // Slice the tagged sample: non-negative decides 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= tag_q;
      if (tag_q)
        bit_q <= ~acc_q[ACC_NBITS-1];
    end
  end

  assign bus.rx_bit   = bit_q;
  assign bus.rx_valid = valid_q;

endmodule

// File: tb/tb_rx_matched_filter.sv
// Randomized bench for rx_matched_filter against an arithmetic model.
// Four instances share stimulus: unit taps, max taps, mixed taps, U=3.
module tb_rx_matched_filter;

  localparam int N  = 24;
  localparam int NI = 4;

  localparam logic [N*8-1:0] C_ONE = {N{8'h01}};
  localparam logic [N*8-1:0] C_MAX = {N{8'h7F}};
  localparam logic [N*8-1:0] C_MIX = {
    8'hFE, 8'hFC, 8'h00, 8'h06, 8'h0A, 8'h06, 8'hF8, 8'hE8,
    8'hF0, 8'h1C, 8'h50, 8'h70, 8'h70, 8'h50, 8'h1C, 8'hF0,
    8'hE8, 8'hF8, 8'h06, 8'h0A, 8'h06, 8'h00, 8'hFC, 8'hFE};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [7:0] rx  = 8'h00;
  logic [1:0] ph  = 2'd0;

  logic       dv [NI];
  logic       db [NI];
  logic [7:0] ds [NI];

  always #5 clk = ~clk;

  rx_matched_filter_if #(
    .IN_NBITS(8), .OUT_NBITS(8), .PHASE_NBITS(2)
  ) bi [NI] ();

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign bi[g].enable = en;
    assign bi[g].rx_in  = rx;
    assign bi[g].phase  = (g == 3) ? 2'd3 : ph;
    assign dv[g] = bi[g].rx_valid;
    assign db[g] = bi[g].rx_bit;
`ifdef RX_SOFT_EN
    assign ds[g] = bi[g].rx_soft;
`else
    assign ds[g] = 8'h00;
`endif
    rx_matched_filter #(
      .UPSAMPLE((g == 3) ? 3 : 4),
      .NCOEF(N),
      .COEF_NBITS(8),
      .COEF((g == 0) ? C_ONE : (g == 1) ? C_MAX :
            (g == 2) ? C_MIX : C_ONE),
      .COEF_FBITS(7),
      .IN_NBITS(8),
      .IN_FBITS(7),
      .OUT_NBITS(8),
      .OUT_FBITS(7)
    ) dut (
      .clk(clk),
      .reset(rst),
      .bus(bi[g])
    );
  end

  typedef struct {
    int due;
    bit b;
    int s;
  } ev_t;

  int  coef [NI][N];
  int  hist [NI][N];
  int  nsamp [NI];
  int  uu [NI] = '{4, 4, 4, 3};
  ev_t evq [NI][$];
  int  exp_v [NI];
  int  exp_b [NI];
  int  exp_s [NI];
  int  nstb [NI];
  int  stb3_total;
  int  cyc;
  int  n_cmp;
  int  n_err;

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d",
               name, cyc, act, expv);
    end
  endtask

  function automatic int msum(input int i);
    int s = 0;
    for (int k = 0; k < N; k++) s += coef[i][k] * hist[i][k];
    return s;
  endfunction

  function automatic int msoft(input int s);
    int t = s >>> 7;
    if (t > 127) t = 127;
    if (t < -128) t = -128;
    return t & 255;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < N; k++) hist[i][k] = 0;
      nsamp[i] = 0;
      evq[i].delete();
      exp_v[i] = 0;
      exp_b[i] = 0;
      exp_s[i] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      exp_v[i] = 0;
      if (evq[i].size() > 0 && evq[i][0].due == cyc) begin
        exp_v[i] = 1;
        exp_b[i] = int'(evq[i][0].b);
        exp_s[i] = evq[i][0].s;
        void'(evq[i].pop_front());
      end
      if (!rst && en) begin
        int pi;
        int s;
        for (int k = N-1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = int'($signed(rx));
        pi = (i == 3) ? 3 : int'(ph);
        if ((nsamp[i] % uu[i]) == pi) begin
          ev_t e;
          s = msum(i);
          e.due = cyc + 2;
          e.b = (s >= 0);
          e.s = msoft(s);
          evq[i].push_back(e);
        end
        nsamp[i]++;
      end
    end
    #1;
    for (int i = 0; i < NI; i++) nstb[i] += int'(dv[i]);
    stb3_total += int'(dv[3]);
  endtask

  task automatic cycle(input bit r, input bit e, input logic [7:0] x);
    @(negedge clk);
    rst = r;
    en  = e;
    rx  = x;
    tick();
  endtask

  task automatic clear_stb();
    for (int i = 0; i < NI; i++) nstb[i] = 0;
  endtask

  // Per-cycle comparison of every instance against the model
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("valid%0d", i), int'(dv[i]), exp_v[i]);
      chk($sformatf("bit%0d", i), int'(db[i]), exp_b[i]);
`ifdef RX_SOFT_EN
      chk($sformatf("soft%0d", i), int'(ds[i]), exp_s[i]);
`endif
    end
  end

  initial begin
    logic [N*8-1:0] p;
    n_cmp = 0;
    n_err = 0;
    cyc = 0;
    stb3_total = 0;
    for (int i = 0; i < NI; i++) begin
      p = (i == 0) ? C_ONE : (i == 1) ? C_MAX :
          (i == 2) ? C_MIX : C_ONE;
      for (int k = 0; k < N; k++)
        coef[i][k] = int'($signed(p[(N-k)*8-1 -: 8]));
    end
    model_clear();
    clear_stb();

    repeat (3) cycle(1'b1, 1'b1, 8'h40);

    // Unit taps, constant 0.5 input
    ph = 2'd0;
    repeat (40) cycle(1'b0, 1'b1, 8'h40);
    clear_stb();
    repeat (40) cycle(1'b0, 1'b1, 8'h40);
    chk("rate_full", nstb[0], 10);
    chk("t2_bit", int'(db[0]), 1);
    chk("t2_model_soft", exp_s[0], 12);
`ifdef RX_SOFT_EN
    chk("t2_soft", int'(ds[0]), 8'h0C);
`endif

    // Max taps, full-scale positive then negative
    repeat (40) cycle(1'b0, 1'b1, 8'h7F);
    chk("t3_bit_pos", int'(db[1]), 1);
    chk("t3_model_pos", exp_s[1], 8'h7F);
`ifdef RX_SOFT_EN
    chk("t3_soft_pos", int'(ds[1]), 8'h7F);
`endif
    repeat (40) cycle(1'b0, 1'b1, 8'h80);
    chk("t3_bit_neg", int'(db[1]), 0);
    chk("t3_model_neg", exp_s[1], 8'h80);
`ifdef RX_SOFT_EN
    chk("t3_soft_neg", int'(ds[1]), 8'h80);
`endif

    // Alternating enable halves the strobe rate
    for (int c = 0; c < 16; c++)
      cycle(1'b0, c[0] == 1'b0, 8'($urandom));
    clear_stb();
    for (int c = 0; c < 80; c++)
      cycle(1'b0, c[0] == 1'b0, 8'($urandom));
    chk("rate_gated", nstb[0], 10);

    // Phase change mid-stream
    ph = 2'd3;
    repeat (20) cycle(1'b0, 1'b1, 8'($urandom));
    ph = 2'd1;
    repeat (20) cycle(1'b0, 1'b1, 8'($urandom));

    // Random samples, gating and phase
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) ph = 2'($urandom_range(0, 3));
      cycle(1'b0, ($urandom % 4) != 0, 8'($urandom));
    end

    // Reset mid-stream right after a tagged sample
    ph = 2'd0;
    repeat (9) cycle(1'b0, 1'b1, 8'h30);
    #1;
    rst = 1'b1;
    model_clear();
    #1;
    chk("rst_valid", int'(dv[0]), 0);
    chk("rst_bit", int'(db[0]), 0);
    chk("rst_bit2", int'(db[2]), 0);
`ifdef RX_SOFT_EN
    chk("rst_soft", int'(ds[0]), 0);
`endif
    repeat (2) cycle(1'b1, 1'b1, 8'h30);
    cycle(1'b0, 1'b1, 8'h30);
    chk("post_rst_e1", int'(dv[0]), 0);
    cycle(1'b0, 1'b1, 8'h30);
    chk("post_rst_e2", int'(dv[0]), 0);
    cycle(1'b0, 1'b1, 8'h30);
    chk("post_rst_e3", int'(dv[0]), 1);
    chk("post_rst_bit", int'(db[0]), 1);

    for (int c = 0; c < 300; c++) begin
      if (c % 40 == 0) ph = 2'($urandom_range(0, 3));
      cycle(1'b0, ($urandom % 3) != 0, 8'($urandom));
    end

    chk("u3_ph3_never", stb3_total, 0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
